// File: rtl/dot_acc_pkg.sv
// Shared constants and types for the dot-product accumulator stage.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   P_W_DEF / ACC_W_DEF / CNT_W_DEF : default product, accumulator and term-counter widths
//   state_e                         : control state, ACCUM (taking beats) or HOLD (result pending)
//   zext_p                          : zero-extends a product to accumulator-plus-carry width
package dot_acc_pkg;

    localparam int P_W_DEF   = 6;
    localparam int ACC_W_DEF = 10;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Zero-extends a P_W_DEF-wide product into an ACC_W_DEF+1 wide word.
    // The extra top bit holds the carry of the accumulator add.
    function automatic logic [ACC_W_DEF:0] zext_p(input logic [P_W_DEF-1:0] p);
        return {{(ACC_W_DEF + 1 - P_W_DEF){1'b0}}, p};
    endfunction

endpackage

// File: rtl/dot_acc_33_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, returns sum and carry flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   acc_i  [ACC_W-1:0] current accumulator value
//   p_i    [P_W-1:0]   unsigned product to add
//   sum_o  [ACC_W-1:0] new accumulator value (wrapped, or clamped when saturating)
//   flag_o             carry-out of the add; with saturation this means "clamped"
// Build option: DOT_ACC_SAT_EN selects saturating instead of modular addition.
module acc_add #(
    parameter int P_W   = 6,
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [P_W-1:0]   p_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             flag_o
);

    localparam int EXT_W = ACC_W + 1 - P_W;

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc_i} + {{EXT_W{1'b0}}, p_i};
        flag_o   = wide_sum[ACC_W];
`ifdef DOT_ACC_SAT_EN
        // Clamp to all-ones on carry. An accumulator already at max carries
        // again on any non-zero product, so it stays pinned for the packet.
        sum_o = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum_o = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/dot_acc_33.sv
// Dot-product accumulator: sums product beats per packet and emits sum, term count, overflow flag.
// Latency: result valid the cycle after the last beat is accepted; 2-cycle packet-to-packet minimum.
// Backpressure: in_ready drops for the whole HOLD state; the result is held until out_ready.
//
// Ports:
//   clk, rst_n                    clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_p/in_last product beat handshake, in_last marks end of packet
//   out_valid/out_ready           result handshake
//   out_sum/out_cnt/out_ovf       packet sum, number of beats (mod 2^CNT_W), sticky carry
// Build option: DOT_ACC_SAT_EN (saturating accumulator, handled inside acc_add).
module dot_acc_33
    import dot_acc_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    state_e             state_q,     state_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
    logic               out_ovf_q,   out_ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_flag;
    logic [CNT_W-1:0]   cnt_inc;
    logic               beat_acc;

    acc_add #(
        .P_W   (P_W),
        .ACC_W (ACC_W)
    ) u_acc_add (
        .acc_i  (acc_q),
        .p_i    (in_p),
        .sum_o  (add_sum),
        .flag_o (add_flag)
    );

    // Ready is a pure decode of the state register, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q == ACCUM);
    assign beat_acc  = in_valid && in_ready;
    assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        unique case (state_q)
            ACCUM: begin
                // in_p only matters when a beat is actually taken, so an
                // undriven product on idle cycles cannot leak into state.
                if (beat_acc) begin
                    if (in_last) begin
                        out_sum_d   = add_sum;
                        out_cnt_d   = cnt_inc;
                        out_ovf_d   = ovf_q | add_flag;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_flag;
                    end
                end
            end
            HOLD: begin
                // Result registers are left untouched so they stay stable
                // for the consumer until the handshake completes.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_dot_acc_33.sv
// Self-checking bench for dot_acc_33: vector table, hand-written corner sequences,
// and randomized packets checked against an arithmetic packet model.
module tb_dot_acc_33;

    localparam int P_W   = 6;
    localparam int ACC_W = 10;
    localparam int CNT_W = 4;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [P_W-1:0]   in_p;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int checks;
    int errors;

    dot_acc_33 #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Packet model: total of all products and beat count, straight arithmetic.
    task automatic model(input int total, input int n,
                         output int s, output int c, output int o);
`ifdef DOT_ACC_SAT_EN
        s = (total > ACC_MOD - 1) ? ACC_MOD - 1 : total;
`else
        s = total % ACC_MOD;
`endif
        o = (total > ACC_MOD - 1) ? 1 : 0;
        c = n % CNT_MOD;
    endtask

    // One beat, preceded by 'gap' idle cycles; returns 1 time unit after the accepting edge.
    task automatic beat(input int p, input bit last, input int gap);
        int w;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            chk("idle_no_result", int'(out_valid), 0);
        end
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
        in_valid = 1'b1;
        in_p     = p[P_W-1:0];
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_p     = 'x;
    endtask

    // Waits (bounded) for a result, holds it for 'hold' cycles checking stability, then handshakes.
    task automatic get_result(input string tag, input int es, input int ec, input int eo,
                              input int hold);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, int'(out_valid), 1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_sum"}, int'(out_sum), es);
            chk({tag, "_hold_rdy"}, int'(in_ready), 0);
            @(negedge clk);
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
        end
        chk({tag, "_sum"}, int'(out_sum), es);
        chk({tag, "_cnt"}, int'(out_cnt), ec);
        chk({tag, "_ovf"}, int'(out_ovf), eo);
        chk({tag, "_in_ready_hold"}, int'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, int'(out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    typedef struct {
        int n;
        int p0;
        int p1;
        int p2;
        int exp_sum;
        int exp_cnt;
        int exp_ovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int s, c, o, total, n, p, hold;
        int plist[$];

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_p      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum",   int'(out_sum),   0);
        chk("rst_out_cnt",   int'(out_cnt),   0);
        chk("rst_out_ovf",   int'(out_ovf),   0);
        chk("rst_in_ready",  int'(in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: beats and expected result.
        vecs[0] = '{3, 15, 49, 12, 76, 3, 0};
        vecs[1] = '{1,  0,  0,  0,  0, 1, 0};
        vecs[2] = '{1, 49,  0,  0, 49, 1, 0};
        vecs[3] = '{2, 63, 63,  0,126, 2, 0};
        vecs[4] = '{3,  0,  0,  0,  0, 3, 0};

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                p = (b == 0) ? vecs[v].p0 : (b == 1) ? vecs[v].p1 : vecs[v].p2;
                beat(p, (b == vecs[v].n - 1), 0);
            end
            chk($sformatf("vec%0d_latency", v), int'(out_valid), 1);
            get_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt,
                       vecs[v].exp_ovf, 0);
        end

        // Back-pressure: result held 3 cycles while a beat waits at the input.
        beat(15, 0, 0);
        beat(49, 0, 0);
        beat(12, 1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_p     = 6'd5;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid",    int'(out_valid), 1);
            chk("bp_sum",      int'(out_sum),   76);
            chk("bp_cnt",      int'(out_cnt),   3);
            chk("bp_ovf",      int'(out_ovf),   0);
            chk("bp_in_ready", int'(in_ready),  0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_hs_valid",    int'(out_valid), 0);
        chk("bp_hs_in_ready", int'(in_ready),  1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_next_sum",   int'(out_sum),   5);
        chk("bp_next_cnt",   int'(out_cnt),   1);
        get_result("bp_next", 5, 1, 0, 0);

        // Overflow: 21 beats of 49 (total 1029).
        for (int b = 0; b < 21; b++) beat(49, (b == 20), 0);
        model(21 * 49, 21, s, c, o);
        get_result("ovf", s, c, o, 0);
        // Accumulator and sticky flag clear for the next packet.
        beat(49, 1, 0);
        get_result("ovf_after", 49, 1, 0, 0);

        // Gaps between beats.
        beat(7, 0, 0);
        beat(7, 0, 2);
        beat(7, 1, 3);
        get_result("gaps", 21, 3, 0, 1);

        // Reset mid-packet (out_sum still shows 21 from the previous packet).
        beat(10, 0, 0);
        beat(20, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstpkt_sum",      int'(out_sum),   0);
        chk("rstpkt_cnt",      int'(out_cnt),   0);
        chk("rstpkt_valid",    int'(out_valid), 0);
        chk("rstpkt_in_ready", int'(in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in HOLD.
        beat(30, 0, 0);
        beat(33, 1, 0);
        chk("rsthold_pre_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rsthold_valid",    int'(out_valid), 0);
        chk("rsthold_sum",      int'(out_sum),   0);
        chk("rsthold_cnt",      int'(out_cnt),   0);
        chk("rsthold_in_ready", int'(in_ready),  1);
        @(negedge clk);
        rst_n = 1'b1;
        beat(10, 0, 0);
        beat(20, 1, 0);
        get_result("post_rst", 30, 2, 0, 0);

        // Randomized packets against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 26);
            plist.delete();
            total = 0;
            for (int b = 0; b < n; b++) begin
                p = $urandom_range(0, 7) * $urandom_range(0, 7);
                plist.push_back(p);
                total += p;
            end
            for (int b = 0; b < n; b++)
                beat(plist[b], (b == n - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            model(total, n, s, c, o);
            hold = $urandom_range(0, 3);
            get_result($sformatf("rnd%0d", k), s, c, o, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
